branch_predictor: RTL

//  Fetch-side counterpart of the execute-stage branch resolver.

---
 rtl/branch_predictor_if.sv | 38 +++
 rtl/branch_predictor.sv | 79 +++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-lookup and execute-resolve bundle of the branch predictor
//  slave  : predictor side (takes if_*/ex_* requests, drives pred_*, ex_mispredict, stats)
//  master : fetch/execute side (drives requests, observes predictions and stats)
`ifndef XLEN
`define XLEN 32
`endif
interface branch_predictor_if #(
   parameter int BHT_IDX = 6,
   parameter int CNT_W   = 32
);
   logic               if_valid;
   logic [`XLEN-1:0]   if_pc;
   logic               pred_taken;
   logic [`XLEN-1:0]   pred_target;
   logic               pred_hit;
   logic [BHT_IDX-1:0] pred_ghr;
   logic               ex_valid;
   logic [`XLEN-1:0]   ex_pc;
   logic               ex_is_cond;
   logic               ex_taken;
   logic [`XLEN-1:0]   ex_target;
   logic [BHT_IDX-1:0] ex_ghr;
   logic               ex_pred_taken;
   logic [`XLEN-1:0]   ex_pred_target;
   logic               ex_mispredict;
   logic [CNT_W-1:0]   br_cnt;
   logic [CNT_W-1:0]   mispred_cnt;
   modport slave (
      input  if_valid, if_pc, ex_valid, ex_pc, ex_is_cond, ex_taken, ex_target, ex_ghr,
             ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, pred_hit, pred_ghr, ex_mispredict, br_cnt, mispred_cnt
   );
   modport master (
      output if_valid, if_pc, ex_valid, ex_pc, ex_is_cond, ex_taken, ex_target, ex_ghr,
             ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, pred_hit, pred_ghr, ex_mispredict, br_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: gshare 2-bit BHT + direct-mapped BTB fetch predictor with misprediction stats
//  clock, reset_n : rising-edge clock, asynchronous active-low reset
//  bp (slave)     : fetch lookup (if_*/pred_*), execute training (ex_*), br_cnt/mispred_cnt
`ifndef XLEN
`define XLEN 32
`endif
module branch_predictor #(
   parameter int BHT_IDX = 6,
   parameter int BTB_IDX = 5,
   parameter int CNT_W   = 32
) (
   input logic               clock,
   input logic               reset_n,
   branch_predictor_if.slave bp
);
   localparam int TAG_W = `XLEN - BTB_IDX - 2;
   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic [`XLEN-1:0] tgt;
      logic             uncond;
   } btb_t;
   logic [1:0]         bht_q [2**BHT_IDX];
   logic [1:0]         bht_d [2**BHT_IDX];
   btb_t               btb_q [2**BTB_IDX];
   btb_t               btb_d [2**BTB_IDX];
   logic [BHT_IDX-1:0] ghr_q, ghr_d, up_idx;
   logic [CNT_W-1:0]   br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;
   logic [`XLEN-1:0]   ex_next;
   btb_t               rd;
   logic               hit, taken;
   // lookup reads registered state only, so a same-cycle update is seen one cycle later
   assign rd             = btb_q[bp.if_pc[BTB_IDX+1:2]];
   assign hit            = bp.if_valid & rd.v & (rd.tag == bp.if_pc[`XLEN-1:BTB_IDX+2]);
   assign taken          = hit & (rd.uncond | bht_q[bp.if_pc[BHT_IDX+1:2] ^ ghr_q][1]);
   assign bp.pred_hit    = hit;
   assign bp.pred_taken  = taken;
   assign bp.pred_target = taken ? rd.tgt : bp.if_pc + `XLEN'd4;
   assign bp.pred_ghr    = ghr_q;
   assign ex_next          = bp.ex_taken ? bp.ex_target : bp.ex_pc + `XLEN'd4;
   assign bp.ex_mispredict = bp.ex_valid & (ex_next != bp.ex_pred_target);
   assign up_idx           = bp.ex_pc[BHT_IDX+1:2] ^ bp.ex_ghr;
   assign bp.br_cnt        = br_cnt_q;
   assign bp.mispred_cnt   = mispred_cnt_q;
   always_comb begin
      bht_d         = bht_q;
      btb_d         = btb_q;
      ghr_d         = ghr_q;
      br_cnt_d      = br_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (bp.ex_valid && bp.ex_is_cond) begin
         bht_d[up_idx] = bp.ex_taken ? (&bht_q[up_idx] ? 2'b11 : bht_q[up_idx] + 2'd1)
                                     : (|bht_q[up_idx] ? bht_q[up_idx] - 2'd1 : 2'b00);
         ghr_d         = {ghr_q[BHT_IDX-2:0], bp.ex_taken};
         br_cnt_d      = br_cnt_q + CNT_W'(~&br_cnt_q);
      end
      // not-taken conditionals keep their entry; the BHT counter decides direction
      if (bp.ex_valid && bp.ex_taken)
         btb_d[bp.ex_pc[BTB_IDX+1:2]] = '{v: 1'b1, tag: bp.ex_pc[`XLEN-1:BTB_IDX+2],
                                          tgt: bp.ex_target, uncond: ~bp.ex_is_cond};
      if (bp.ex_mispredict)
         mispred_cnt_d = mispred_cnt_q + CNT_W'(~&mispred_cnt_q);
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bht_q         <= '{default: 2'b01};
         btb_q         <= '{default: '0};
         ghr_q         <= '0;
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         bht_q         <= bht_d;
         btb_q         <= btb_d;
         ghr_q         <= ghr_d;
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
endmodule
